// File: rtl/watch_pkg.sv
// watch_pkg: field limits, widths and control-unit state encoding shared by the watch blocks
package watch_pkg;
    localparam int MSEC_MAX = 99;
    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;
    localparam int MSEC_W   = 7;
    localparam int SEC_W    = 6;
    localparam int MIN_W    = 6;
    localparam int HOUR_W   = 5;
    typedef enum logic [1:0] {CU_RUN, CU_SET_HOUR, CU_SET_MIN, CU_SET_SEC} cu_state_e;
endpackage

// File: rtl/watch_dp_if.sv
// watch_dp_if: control-unit load/clear/set-mode signals and time outputs toward the display
interface watch_dp_if;
    import watch_pkg::*;
    logic              i_hour_set;
    logic              i_min_set;
    logic              i_sec_set;
    logic [HOUR_W-1:0] i_hour_value;
    logic [MIN_W-1:0]  i_min_value;
    logic [SEC_W-1:0]  i_sec_value;
    logic              i_clear;
    logic              i_set_mode_active;
    logic [MSEC_W-1:0] o_msec;
    logic [SEC_W-1:0]  o_sec;
    logic [MIN_W-1:0]  o_min;
    logic [HOUR_W-1:0] o_hour;
    logic              o_tick;
    modport master (
        output i_hour_set, i_min_set, i_sec_set, i_hour_value, i_min_value, i_sec_value,
        output i_clear, i_set_mode_active,
        input  o_msec, o_sec, o_min, o_hour, o_tick
    );
    modport slave (
        input  i_hour_set, i_min_set, i_sec_set, i_hour_value, i_min_value, i_sec_value,
        input  i_clear, i_set_mode_active,
        output o_msec, o_sec, o_min, o_hour, o_tick
    );
endinterface

// File: rtl/tick_gen.sv
// tick_gen: divides clk by CLK_FREQ/TICK_HZ; o_tick is high in the cycle the count sits at DIV-1
module tick_gen #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int TICK_HZ  = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic i_hold,
    output logic o_tick
);
    localparam int DIV = CLK_FREQ / TICK_HZ;
    localparam int W   = $clog2(DIV);
    logic [W-1:0] cnt;
    assign o_tick = !i_hold && cnt == W'(DIV - 1);
    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt <= '0;
        else      cnt <= (i_hold || o_tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/watch_dp.sv
// watch_dp: cascaded hour:min:sec:centisec counter with field loads, clear and set-mode freeze
module watch_dp
    import watch_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int TICK_HZ  = 100
) (
    input logic        clk,
    input logic        rst,
    watch_dp_if.slave  dp
);
    logic tick;
    logic c_ms;
    logic c_s;
    logic c_m;
    logic [HOUR_W-1:0] hour_ld;
    logic [MIN_W-1:0]  min_ld;
    logic [SEC_W-1:0]  sec_ld;
    // a sec load restarts the centisecond phase, so it holds the prescaler like clear/freeze
    tick_gen #(.CLK_FREQ(CLK_FREQ), .TICK_HZ(TICK_HZ)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .i_hold (dp.i_clear | dp.i_set_mode_active | dp.i_sec_set),
        .o_tick (tick)
    );
    assign hour_ld = dp.i_hour_value > HOUR_W'(HOUR_MAX) ? HOUR_W'(HOUR_MAX) : dp.i_hour_value;
    assign min_ld  = dp.i_min_value  > MIN_W'(MIN_MAX)   ? MIN_W'(MIN_MAX)   : dp.i_min_value;
    assign sec_ld  = dp.i_sec_value  > SEC_W'(SEC_MAX)   ? SEC_W'(SEC_MAX)   : dp.i_sec_value;
    // a loaded field swallows its incoming carry and propagates none upward
    assign c_ms = tick && dp.o_msec == MSEC_W'(MSEC_MAX);
    assign c_s  = c_ms && dp.o_sec == SEC_W'(SEC_MAX) && !dp.i_sec_set;
    assign c_m  = c_s && dp.o_min == MIN_W'(MIN_MAX) && !dp.i_min_set;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            dp.o_msec <= '0;
            dp.o_sec  <= '0;
            dp.o_min  <= '0;
            dp.o_hour <= '0;
            dp.o_tick <= 1'b0;
        end else if (dp.i_clear) begin
            dp.o_msec <= '0;
            dp.o_sec  <= '0;
            dp.o_min  <= '0;
            dp.o_hour <= '0;
            dp.o_tick <= 1'b0;
        end else begin
            dp.o_tick <= tick;
            dp.o_msec <= dp.i_sec_set ? '0 : tick ? (c_ms ? '0 : dp.o_msec + 1'b1) : dp.o_msec;
            dp.o_sec  <= dp.i_sec_set ? sec_ld :
                         c_ms ? (dp.o_sec == SEC_W'(SEC_MAX) ? '0 : dp.o_sec + 1'b1) : dp.o_sec;
            dp.o_min  <= dp.i_min_set ? min_ld :
                         c_s ? (dp.o_min == MIN_W'(MIN_MAX) ? '0 : dp.o_min + 1'b1) : dp.o_min;
            dp.o_hour <= dp.i_hour_set ? hour_ld :
                         c_m ? (dp.o_hour == HOUR_W'(HOUR_MAX) ? '0 : dp.o_hour + 1'b1) : dp.o_hour;
        end
endmodule

// File: tb/tb_watch_dp.sv
// tb_watch_dp: random and directed stimulus checked against a centiseconds-of-day reference model
module tb_watch_dp;
    import watch_pkg::*;
    localparam int DIV = 10;
    localparam int DAY = 24 * 3600 * 100;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int n_chk = 0;
    int n_fail = 0;
    int mt = 0;
    int mph = 0;
    bit mtk = 1'b0;
    watch_dp_if w();
    watch_dp #(.CLK_FREQ(1000), .TICK_HZ(100)) dut (.clk(clk), .rst(rst), .dp(w.slave));
    always #5 clk = ~clk;

    function automatic logic [23:0] tm();
        return {w.o_hour, w.o_min, w.o_sec, w.o_msec};
    endfunction
    function automatic logic [24:0] dut_vec();
        return {tm(), w.o_tick};
    endfunction
    function automatic logic [24:0] exp_vec();
        return {5'(mt / 360000), 6'((mt / 6000) % 60), 6'((mt / 100) % 60), 7'(mt % 100), mtk};
    endfunction
    function automatic int lim(int v, int mx);
        return v > mx ? mx : v;
    endfunction

    // the time is one number of centiseconds; loads rewrite a field of the decomposed value
    function automatic void mdl_step();
        int h, m, nh, nm, ns, nc;
        bit hold, tk;
        if (!rst || w.i_clear) begin
            mt = 0; mph = 0; mtk = 0;
            return;
        end
        hold = w.i_set_mode_active || w.i_sec_set;
        tk = !hold && mph == DIV - 1;
        mph = (hold || tk) ? 0 : mph + 1;
        mtk = tk;
        h = mt / 360000;
        m = (mt / 6000) % 60;
        if (tk) mt = (mt + 1) % DAY;
        nh = mt / 360000;
        nm = (mt / 6000) % 60;
        ns = (mt / 100) % 60;
        nc = mt % 100;
        if (w.i_sec_set) begin ns = lim(int'(w.i_sec_value), 59); nc = 0; nm = m; nh = h; end
        if (w.i_min_set) begin nm = lim(int'(w.i_min_value), 59); nh = h; end
        if (w.i_hour_set) nh = lim(int'(w.i_hour_value), 23);
        mt = ((nh * 60 + nm) * 60 + ns) * 100 + nc;
    endfunction

    task automatic step();
        @(posedge clk);
        mdl_step();
        #1;
    endtask

    task automatic test_reset();
        #1;
        n_chk++;
        if (dut_vec() !== 25'd0) begin n_fail++; $display("FAIL reset_async got %h want 0", dut_vec()); end
        step(); step();
        n_chk++;
        if (dut_vec() !== 25'd0) begin n_fail++; $display("FAIL reset_held got %h want 0", dut_vec()); end
        rst = 1'b1;
    endtask

    task automatic test_count();
        int ticks = 0, last = 0;
        for (int i = 1; i <= 1000; i++) begin
            step();
            n_chk++;
            if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL count_model cyc %0d got %h want %h", i, dut_vec(), exp_vec()); end
            if (w.o_tick) begin
                n_chk++;
                if (i - last !== DIV) begin n_fail++; $display("FAIL tick_spacing got %0d want %0d", i - last, DIV); end
                last = i;
                ticks++;
            end
        end
        n_chk++;
        if (ticks !== 100) begin n_fail++; $display("FAIL tick_count got %0d want 100", ticks); end
        n_chk++;
        if (tm() !== {5'd0, 6'd0, 6'd1, 7'd0}) begin n_fail++; $display("FAIL count_1s got %h want 00:00:01.00", tm()); end
    endtask

    task automatic test_rollover();
        logic [23:0] prev;
        bit seen = 0;
        w.i_set_mode_active = 1; step();
        w.i_hour_value = 5'd23; w.i_min_value = 6'd59; w.i_sec_value = 6'd59;
        w.i_hour_set = 1; w.i_min_set = 1; w.i_sec_set = 1; step();
        w.i_hour_set = 0; w.i_min_set = 0; w.i_sec_set = 0;
        n_chk++;
        if (tm() !== {5'd23, 6'd59, 6'd59, 7'd0}) begin n_fail++; $display("FAIL preload got %h want 23:59:59.00", tm()); end
        step(); step();
        w.i_set_mode_active = 0;
        for (int i = 1; i <= 1000; i++) begin
            prev = tm();
            step();
            n_chk++;
            if (dut_vec() !== exp_vec() || w.o_hour > 23 || w.o_min > 59 || w.o_sec > 59 || w.o_msec > 99) begin
                n_fail++; $display("FAIL rollover_model cyc %0d got %h want %h", i, dut_vec(), exp_vec());
            end
            if (prev == {5'd23, 6'd59, 6'd59, 7'd99} && tm() == 24'd0) seen = 1;
        end
        n_chk++;
        if (!seen) begin n_fail++; $display("FAIL rollover_edge got none want 23:59:59.99->00:00:00.00"); end
    endtask

    task automatic test_freeze();
        logic [23:0] snap;
        int n = 0;
        for (int i = 0; i < 37; i++) begin
            step();
            n_chk++;
            if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL prefreeze got %h want %h", dut_vec(), exp_vec()); end
        end
        w.i_set_mode_active = 1; step();
        snap = tm();
        for (int i = 0; i < 499; i++) begin
            step();
            n_chk++;
            if (tm() !== snap || w.o_tick !== 1'b0) begin n_fail++; $display("FAIL freeze_hold got %h/%b want %h/0", tm(), w.o_tick, snap); end
        end
        w.i_set_mode_active = 0;
        do begin step(); n++; end while (!w.o_tick && n < 50);
        n_chk++;
        if (n !== DIV) begin n_fail++; $display("FAIL freeze_release_tick got %0d want %0d", n, DIV); end
    endtask

    task automatic test_loads();
        w.i_hour_value = 5'd30; w.i_hour_set = 1; step(); w.i_hour_set = 0;
        n_chk++;
        if (w.o_hour !== 5'd23) begin n_fail++; $display("FAIL hour_sat got %0d want 23", w.o_hour); end
        w.i_min_value = 6'd63; w.i_min_set = 1; step(); w.i_min_set = 0;
        n_chk++;
        if (w.o_min !== 6'd59) begin n_fail++; $display("FAIL min_sat got %0d want 59", w.o_min); end
        w.i_min_value = 6'd60; w.i_min_set = 1; step(); w.i_min_set = 0;
        n_chk++;
        if (w.o_min !== 6'd59) begin n_fail++; $display("FAIL min_sat60 got %0d want 59", w.o_min); end
        w.i_hour_value = 5'd7; w.i_hour_set = 1; step(); w.i_hour_set = 0;
        n_chk++;
        if (w.o_hour !== 5'd7) begin n_fail++; $display("FAIL hour_load got %0d want 7", w.o_hour); end
        repeat (4) step();
        w.i_sec_value = 6'd5; w.i_sec_set = 1; step(); w.i_sec_set = 0;
        n_chk++;
        if (w.o_sec !== 6'd5 || w.o_msec !== 7'd0) begin n_fail++; $display("FAIL sec_load got %0d.%0d want 5.0", w.o_sec, w.o_msec); end
        n_chk++;
        if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL loads_model got %h want %h", dut_vec(), exp_vec()); end
    endtask

    task automatic test_clear();
        int n = 0;
        w.i_set_mode_active = 1; step();
        w.i_hour_value = 5'd12; w.i_min_value = 6'd34; w.i_sec_value = 6'd56;
        w.i_hour_set = 1; w.i_min_set = 1; w.i_sec_set = 1; step();
        w.i_hour_set = 0; w.i_min_set = 0; w.i_sec_set = 0; w.i_set_mode_active = 0;
        do begin
            step(); n++;
            n_chk++;
            if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL preclear_model got %h want %h", dut_vec(), exp_vec()); end
        end while (w.o_msec != 7'd78 && n < 2000);
        n_chk++;
        if (tm() !== {5'd12, 6'd34, 6'd56, 7'd78}) begin n_fail++; $display("FAIL preclear_time got %h want 12:34:56.78", tm()); end
        w.i_clear = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_chk++;
            if (dut_vec() !== 25'd0) begin n_fail++; $display("FAIL clear_hold cyc %0d got %h want 0", i, dut_vec()); end
        end
        w.i_clear = 0;
        n = 0;
        do begin step(); n++; end while (!w.o_tick && n < 50);
        n_chk++;
        if (n !== DIV || tm() !== 24'd1) begin n_fail++; $display("FAIL clear_restart got %0d/%h want %0d/00:00:00.01", n, tm(), DIV); end
    endtask

    task automatic test_async_reset();
        int n = 0;
        repeat (23) step();
        #2 rst = 1'b0;
        #1;
        n_chk++;
        if (dut_vec() !== 25'd0) begin n_fail++; $display("FAIL async_reset got %h want 0", dut_vec()); end
        mt = 0; mph = 0; mtk = 0;
        step();
        rst = 1'b1;
        do begin step(); n++; end while (!w.o_tick && n < 50);
        n_chk++;
        if (n !== DIV || tm() !== 24'd1) begin n_fail++; $display("FAIL reset_restart got %0d/%h want %0d/00:00:00.01", n, tm(), DIV); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 6000; i++) begin
            w.i_hour_value = 5'($urandom);
            w.i_min_value = ($urandom % 2) ? 6'(56 + $urandom % 8) : 6'($urandom);
            w.i_sec_value = ($urandom % 2) ? 6'(56 + $urandom % 8) : 6'($urandom);
            w.i_hour_set = (mph == DIV - 1) ? ($urandom % 3 == 0) : ($urandom % 100 == 0);
            w.i_min_set = (mph == DIV - 1) ? ($urandom % 3 == 0) : ($urandom % 100 == 0);
            w.i_sec_set = ($urandom % 700 == 0);
            w.i_clear = ($urandom % 900 == 0);
            if ($urandom % 300 == 0) w.i_set_mode_active = ~w.i_set_mode_active;
            else if (w.i_set_mode_active && $urandom % 8 == 0) w.i_set_mode_active = 0;
            step();
            n_chk++;
            if (dut_vec() !== exp_vec()) begin n_fail++; $display("FAIL random_model cyc %0d got %h want %h", i, dut_vec(), exp_vec()); end
        end
        w.i_hour_set = 0; w.i_min_set = 0; w.i_sec_set = 0; w.i_clear = 0; w.i_set_mode_active = 0;
    endtask

    initial begin
        w.i_hour_set = 0; w.i_min_set = 0; w.i_sec_set = 0;
        w.i_hour_value = '0; w.i_min_value = '0; w.i_sec_value = '0;
        w.i_clear = 0; w.i_set_mode_active = 0;
        test_reset();
        test_count();
        test_rollover();
        test_freeze();
        test_loads();
        test_clear();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/watch_dp.md
Name: watch_dp

Overview:
- Timekeeping datapath directly downstream of the watch control unit.
- Divides the system clock into a centisecond tick and runs a cascaded hour:min:sec:centisec counter.
- Accepts single-cycle field-load pulses and values from the control unit, plus the control unit's clear level and set-mode flag.
- Outputs feed the FND display formatter.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- TICK_HZ, 100, centisecond tick rate in Hz. DIV = CLK_FREQ/TICK_HZ, which must be an integer ≥ 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- i_hour_set  in  1  one-cycle pulse: load i_hour_value.
- i_min_set  in  1  one-cycle pulse: load i_min_value.
- i_sec_set  in  1  one-cycle pulse: load i_sec_value.
- i_hour_value  in  5  hour load value.
- i_min_value  in  6  minute load value.
- i_sec_value  in  6  second load value.
- i_clear  in  1  level: hold the time at zero while high.
- i_set_mode_active  in  1  level: freeze timekeeping while high.
- o_msec  out  7  centiseconds, 0..99.
- o_sec  out  6  seconds, 0..59.
- o_min  out  6  minutes, 0..59.
- o_hour  out  5  hours, 0..23.
- o_tick  out  1  one-cycle pulse on each centisecond advance.

Behaviour:
- Reset:
  - rst low immediately forces the prescaler and all of o_msec/o_sec/o_min/o_hour/o_tick to 0, independent of clk.
  - Normal counting resumes on the first clk edge after rst returns high.
- Prescaler:
  - Counts 0..DIV-1 and wraps to 0.
  - An internal tick asserts for the one cycle in which the count equals DIV-1.
  - The prescaler width is the minimum needed to hold DIV-1.
- Advance on tick, in the same clk edge:
  - msec increments. At 99 it wraps to 0 and carries into sec.
  - sec wraps 59->0 and carries into min.
  - min wraps 59->0 and carries into hour.
  - hour wraps 23->0.
  - The full rollover 23:59:59.99 -> 00:00:00.00 completes in a single edge.
- o_tick: registered, high in the cycle after the counters update, for exactly 1 cycle.
- All time outputs are registered. Output latency is 1 clk from tick, load, or clear.
- Set-mode freeze (i_set_mode_active high):
  - Prescaler held at 0, ticks suppressed, time fields hold.
  - On release, the first tick occurs DIV cycles later.
- Field loads, on the edge where the pulse is high:
  - The addressed field takes its value.
  - Values out of range saturate: hour >23 -> 23; min or sec >59 -> 59.
  - A sec load also zeroes msec and the prescaler.
  - Multiple set pulses in the same cycle each load their own field.
- Clear (i_clear high):
  - All fields and the prescaler are held at 0. No o_tick.
  - Counting restarts from 0 the cycle after i_clear falls, unless set mode is active.
- Priority per edge: clear > loads > freeze > tick.
  - A load coinciding with a tick wins for the loaded field.
  - Carries into the loaded field are discarded.
  - Lower fields still advance normally.
- No internal state machine beyond the prescaler. All state is counters.

Decomposition:
- Shared package watch_pkg holds:
  - Constants MSEC_MAX=99, SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23.
  - Field widths MSEC_W=7, SEC_W=6, MIN_W=6, HOUR_W=5.
  - The control-unit state encoding, shared with the control unit.
- One sub-module, tick_gen:
  - Parameters CLK_FREQ, TICK_HZ.
  - Ports clk, rst, i_hold (clear OR set-mode OR sec-load), o_tick.
  - Instantiated once.
- The cascaded counters live in watch_dp.

Test Plan (CLK_FREQ=1000, TICK_HZ=100, so DIV=10):
- Reset then run 1000 cycles -> o_msec=0, o_sec=1, o_min=0, o_hour=0; o_tick seen 100 times, each 10 cycles apart.
- Load hour=23, min=59, sec=59 with set-mode active, release, run 1000 cycles -> 00:00:00.00 on the rollover edge and no intermediate illegal value.
- i_set_mode_active high for 500 cycles mid-count -> outputs constant and no o_tick; after release, first o_tick exactly 10 cycles later.
- i_hour_set with i_hour_value=30 -> o_hour=23; i_min_set with value 63 -> o_min=59; i_sec_set with value 5 -> o_sec=5, o_msec=0.
- i_clear high for 3 cycles at 12:34:56.78 -> 00:00:00.00 one cycle after assertion, held while high; first o_tick 10 cycles after i_clear falls.
- Assert rst low asynchronously mid-cycle while counting -> all outputs 0 before the next clk edge; release -> counting restarts from the prescaler at 0.
